// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: OBI request/grant/rvalid port to classic Wishbone master.
// One WB transaction in flight at a time; responses queue in a small FIFO
// that the core drains with rready_i.
// Optional macro OBI_WB_TIMEOUT_EN: abort a WB cycle that waits
// TIMEOUT_CYCLES without ack/err and answer with an error response.
//
// Handshakes: an OBI request transfers on req_i && gnt_o; a response
// transfers on rvalid_o && rready_i, and rvalid_o/rdata_o/err_o stay stable
// until that happens. A WB cycle ends on the first edge with ack_i || err_i
// while cyc_o && stb_o are high.
module obi_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RESP_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic                    ack_i,
  input  logic                    err_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  // Elaboration-time sanity checks on the configuration
  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (RESP_DEPTH < 1) begin : g_chk_depth
    $error("RESP_DEPTH must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic [DATA_WIDTH-1:0] mem_data_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [RESP_DEPTH];
  logic                  mem_err_q  [RESP_DEPTH];
  logic                  mem_err_d  [RESP_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  fifo_free;
  logic                  push, pop, push_err;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  bus_resp;
  logic                  tmo_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_free = (count_q < CNT_W'(RESP_DEPTH));
  assign bus_resp  = (state_q == BUS) && (ack_i || err_i);

`ifdef OBI_WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Timeout fires in the BUS cycle where the wait count reaches the limit
  assign tmo_hit = (state_q == BUS) && !(ack_i || err_i) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared on grant, counts BUS cycles without a response
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE) tmo_d = '0;
    else if (!(ack_i || err_i) && !tmo_hit) tmo_d = tmo_q + TMO_W'(1);
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Grant only from IDLE with a slot already free; gated by reset
  assign gnt_o = rst_n && (state_q == IDLE) && req_i && fifo_free;

  // FSM next state and request capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (gnt_o) begin
          addr_d  = addr_i;
          we_d    = we_i;
          sel_d   = be_i;
          dat_d   = we_i ? wdata_i : '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus_resp || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and WB request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  assign cyc_o  = (state_q == BUS);
  assign stb_o  = (state_q == BUS);
  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign sel_o  = sel_q;
  assign dat_o  = dat_q;

  // Response entry: read data only for reads; ack+err together is an error.
  // The FIFO cannot be full here because grant required a free slot.
  assign push      = bus_resp || tmo_hit;
  assign push_err  = err_i || tmo_hit;
  assign push_data = (bus_resp && !we_q) ? dat_i : '0;
  assign pop       = rvalid_o && rready_i;

  // Response FIFO next state
  always_comb begin
    mem_data_d = mem_data_q;
    mem_err_d  = mem_err_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = push_data;
      mem_err_d[wr_ptr_q]  = push_err;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Response FIFO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_err_q[i]  <= 1'b0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_err_q  <= mem_err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign rvalid_o = (count_q != '0);
  assign rdata_o  = rvalid_o ? mem_data_q[rd_ptr_q] : '0;
  assign err_o    = rvalid_o ? mem_err_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed bench for obi_wb_bridge: a vector table of single transactions
// plus hand-written sequences for backpressure, reset and timeout.
module tb_obi_wb_bridge;

`ifdef OBI_WB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, gnt_o, we_i, rvalid_o, rready_i, err_o;
  logic [31:0] addr_i, wdata_i, rdata_o, addr_o, dat_o, dat_i;
  logic [3:0]  be_i, sel_o;
  logic        cyc_o, stb_o, we_o, ack_i, err_i;

  int n_cmp = 0;
  int n_bad = 0;

  obi_wb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_DEPTH(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o),
    .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] bus_dat;
    logic        ack;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle step: land 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
  endtask

  // Issue one request, answer it after v.waits wait cycles, check response
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; be_i = v.be; wdata_i = v.wdata;
    #1 chk({t, "_gnt"}, 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0; wdata_i = 32'hFFFF_FFFF;
    chk({t, "_cyc"}, 32'(cyc_o), 32'd1);
    chk({t, "_stb"}, 32'(stb_o), 32'd1);
    chk({t, "_we"}, 32'(we_o), 32'(v.we));
    chk({t, "_addr"}, addr_o, v.addr);
    chk({t, "_sel"}, 32'(sel_o), 32'(v.be));
    chk({t, "_dat"}, dat_o, v.we ? v.wdata : 32'd0);
    for (int i = 0; i < v.waits; i++) begin
      tick();
      chk({t, "_wait_cyc"}, 32'(cyc_o), 32'd1);
      chk({t, "_wait_rvalid"}, 32'(rvalid_o), 32'd0);
    end
    ack_i = v.ack; err_i = v.err; dat_i = v.bus_dat;
    req_i = 1'b1; addr_i = 32'h0000_0BAD;
    #1 chk({t, "_ack_cycle_gnt"}, 32'(gnt_o), 32'd0);
    tick();
    req_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; dat_i = 32'h5A5A_5A5A;
    chk({t, "_end_cyc"}, 32'(cyc_o), 32'd0);
    chk({t, "_rvalid"}, 32'(rvalid_o), 32'd1);
    chk({t, "_rdata"}, rdata_o, v.exp_rdata);
    chk({t, "_err"}, 32'(err_o), 32'(v.exp_err));
    tick();
    chk({t, "_popped"}, 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    //               we    addr          be       wdata         waits dat_i        ack   err   exp_rdata     exp_err
    vecs[0] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0,         0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0100, 4'b0011, 32'h1234_5678, 3, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h0000_0200, 4'b1111, 32'h0,         0, 32'h0000_0055, 1'b1, 1'b1, 32'h0000_0055, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0204, 4'b1100, 32'h0,         1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0300, 4'b1000, 32'h8765_4321, 2, 32'h1111_1111, 1'b0, 1'b1, 32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h0000_0304, 4'b0100, 32'h0,         0, 32'h0000_0077, 1'b0, 1'b1, 32'h0000_0077, 1'b1};

    // Reset state (request pending while in reset)
    idle_inputs();
    rready_i = 1'b1;
    rst_n = 1'b0;
    req_i = 1'b1;
    #3;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    req_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ack/err in IDLE are ignored
    ack_i = 1'b1; err_i = 1'b1; dat_i = 32'h1234_0000;
    tick();
    ack_i = 1'b0; err_i = 1'b0;
    chk("idle_ack_rvalid", 32'(rvalid_o), 32'd0);
    chk("idle_ack_cyc", 32'(cyc_o), 32'd0);

    // Backpressure: three reads with rready_i low, depth 2
    rready_i = 1'b0;
    req_i = 1'b1; addr_i = 32'h10;
    #1 chk("bp_gnt1", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0; ack_i = 1'b1; dat_i = 32'd1;
    tick();
    ack_i = 1'b0; req_i = 1'b1; addr_i = 32'h14;
    #1 chk("bp_gnt2", 32'(gnt_o), 32'd1);
    chk("bp_head1", rdata_o, 32'd1);
    tick();
    req_i = 1'b0; ack_i = 1'b1; dat_i = 32'd2;
    tick();
    ack_i = 1'b0; req_i = 1'b1; addr_i = 32'h18;
    #1 chk("bp_full_gnt", 32'(gnt_o), 32'd0);
    tick();
    chk("bp_full_gnt_held", 32'(gnt_o), 32'd0);
    chk("bp_full_head", rdata_o, 32'd1);
    rready_i = 1'b1;
    #1 chk("bp_same_cycle_pop_gnt", 32'(gnt_o), 32'd0);
    tick();
    chk("bp_gnt3_after_pop", 32'(gnt_o), 32'd1);
    chk("bp_order2", rdata_o, 32'd2);
    tick();
    req_i = 1'b0;
    chk("bp_cyc3", 32'(cyc_o), 32'd1);
    chk("bp_addr3", addr_o, 32'h18);
    chk("bp_drained", 32'(rvalid_o), 32'd0);
    ack_i = 1'b1; dat_i = 32'd3;
    tick();
    ack_i = 1'b0;
    chk("bp_order3", rdata_o, 32'd3);
    chk("bp_rvalid3", 32'(rvalid_o), 32'd1);
    tick();
    chk("bp_empty", 32'(rvalid_o), 32'd0);

    // Reset while a WB cycle is open and one response is queued
    rready_i = 1'b0;
    req_i = 1'b1; addr_i = 32'h40;
    tick();
    req_i = 1'b0; ack_i = 1'b1; dat_i = 32'h99;
    tick();
    ack_i = 1'b0; req_i = 1'b1; addr_i = 32'h44;
    tick();
    req_i = 1'b0;
    chk("mid_cyc_before", 32'(cyc_o), 32'd1);
    chk("mid_rvalid_before", 32'(rvalid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(stb_o), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
    ack_i = 1'b1; dat_i = 32'h77;
    tick();
    ack_i = 1'b0;
    rst_n = 1'b1;
    rready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_post_rvalid", 32'(rvalid_o), 32'd0);
      chk("mid_post_cyc", 32'(cyc_o), 32'd0);
    end

    // Recovery after reset
    run_vec(vecs[0], 10);

`ifdef OBI_WB_TIMEOUT_EN
    // No ack: the cycle is abandoned after TMO BUS cycles
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h80;
    tick();
    req_i = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_cyc_held", 32'(cyc_o), 32'd1);
      tick();
    end
    chk("tmo_cyc_drop", 32'(cyc_o), 32'd0);
    chk("tmo_rvalid", 32'(rvalid_o), 32'd1);
    chk("tmo_err", 32'(err_o), 32'd1);
    chk("tmo_rdata", rdata_o, 32'd0);
    tick();
    ack_i = 1'b1; dat_i = 32'hBEEF;
    tick();
    ack_i = 1'b0;
    chk("tmo_late_ack_rvalid", 32'(rvalid_o), 32'd0);
    tick();
    chk("tmo_late_ack_rvalid2", 32'(rvalid_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
